// File: rtl/axi_pkg.sv
// Shared AXI constants and the burst-generator FSM state type.
package axi_pkg;

    localparam int AXI_LEN_MAX_VALUE       = 256;
    localparam int AXI_FIXED_LEN_MAX_VALUE = 16;
    localparam int AXI_4K_BOUNDARY         = 4096;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } axi_dma_burst_state_e;

endpackage

// File: rtl/axi_dma_req_if.sv
// Burst request / write response channel between the burst generator and the AXI write manager.
interface axi_dma_req_if #(
    parameter int AW    = 32,
    parameter int LEN_W = 32
);
    logic             valid;
    logic             ready;
    logic [AW-1:0]    addr;
    logic [LEN_W-1:0] byte_len;
    logic             fixed;
    logic             lock;
    logic [1:0]       resp;
    logic             resp_valid;

    modport src  (output valid, addr, byte_len, fixed, lock, input  ready, resp, resp_valid);
    modport sink (input  valid, addr, byte_len, fixed, lock, output ready, resp, resp_valid);
endinterface

// File: rtl/axi_dma_burst_calc.sv
// Sizes the next legal AXI burst: limited by remaining bytes, the 4KB page and the max burst length.
module axi_dma_burst_calc
    import axi_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int LEN_W = 32
) (
    input  logic [AW-1:0]    addr,
    input  logic [LEN_W-1:0] remaining,
    input  logic             fixed,
    output logic [LEN_W-1:0] bytes,
    output logic [LEN_W-1:0] byte_len
);
    localparam int BC = DW / 8;
    localparam logic [LEN_W-1:0] INCR_MAX  = LEN_W'(AXI_LEN_MAX_VALUE * BC);
    localparam logic [LEN_W-1:0] FIXED_MAX = LEN_W'(AXI_FIXED_LEN_MAX_VALUE * BC);

    logic [12:0]      bound_dist_s;
    logic [LEN_W-1:0] cap_s;
    logic             unused_addr_s;

    // Only the page offset matters for the boundary distance.
    assign unused_addr_s = ^addr[AW-1:12];

    // Burst size = min(remaining, page distance or FIXED cap, INCR cap).
    always_comb begin
        bound_dist_s = 13'(AXI_4K_BOUNDARY) - {1'b0, addr[11:0]};
        cap_s        = INCR_MAX;
        if (fixed) begin
            cap_s = FIXED_MAX;
        end else if (LEN_W'(bound_dist_s) < INCR_MAX) begin
            cap_s = LEN_W'(bound_dist_s);
        end else begin
            cap_s = INCR_MAX;
        end
        if (remaining < cap_s) begin
            bytes = remaining;
        end else begin
            bytes = cap_s;
        end
        byte_len = bytes - LEN_W'(BC);
    end

endmodule

// File: rtl/axi_dma_wr_burst_gen_chk.sv
// Protocol checker for the burst generator's response channel.
module axi_dma_wr_burst_gen_chk (
    input logic clk,
    input logic rst_n,
    input logic resp_valid,
    input logic out_cnt_zero
);
    // A B response with nothing outstanding is dropped by the generator; flag it.
    assert property (@(posedge clk) disable iff (!rst_n) !(resp_valid && out_cnt_zero));
endmodule

// File: rtl/axi_dma_wr_burst_gen.sv
// Splits one large write command into legal AXI bursts and tracks their B responses.
// Optional abort support is enabled by defining AXI_DMA_WR_BURST_ABORT_EN.
module axi_dma_wr_burst_gen
    import axi_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int LEN_W           = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_byte_cnt,
    input  logic             cmd_fixed,
    input  logic             cmd_lock,
    axi_dma_req_if.src       req_if,
`ifdef AXI_DMA_WR_BURST_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int BC    = DW / 8;
    localparam int BW    = $clog2(BC);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    axi_dma_burst_state_e state_r;
    logic [AW-1:0]        addr_r;
    logic [LEN_W-1:0]     remaining_r;
    logic                 fixed_r;
    logic                 lock_r;
    logic [OUT_W-1:0]     out_cnt_r;
    logic                 valid_r;
    logic                 cmd_ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;
`ifdef AXI_DMA_WR_BURST_ABORT_EN
    logic                 aborted_r;
`endif

    logic [LEN_W-1:0]     burst_bytes_s;
    logic [LEN_W-1:0]     burst_len_s;
    logic                 hs_s;
    logic                 resp_ok_s;
    logic                 bad_resp_s;
    logic                 stop_s;
    logic                 cmd_bad_s;
    logic [OUT_W-1:0]     out_next_s;
    logic [LEN_W-1:0]     remaining_next_s;

    axi_dma_burst_calc #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) u_calc (
        .addr      (addr_r),
        .remaining (remaining_r),
        .fixed     (fixed_r),
        .bytes     (burst_bytes_s),
        .byte_len  (burst_len_s)
    );

    axi_dma_wr_burst_gen_chk u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .resp_valid   (req_if.resp_valid),
        .out_cnt_zero (out_cnt_r == '0)
    );

    // Handshake/response bookkeeping; responses with nothing outstanding are ignored.
    always_comb begin
        hs_s       = valid_r && req_if.ready;
        resp_ok_s  = req_if.resp_valid && (out_cnt_r != '0);
        bad_resp_s = resp_ok_s && (req_if.resp != AXI_RESP_OKAY);
        cmd_bad_s  = (cmd_byte_cnt == '0) || (cmd_addr[BW-1:0] != '0) ||
                     (cmd_byte_cnt[BW-1:0] != '0);
        out_next_s = out_cnt_r;
        if (hs_s && !resp_ok_s) begin
            out_next_s = out_cnt_r + OUT_W'(1);
        end else if (!hs_s && resp_ok_s) begin
            out_next_s = out_cnt_r - OUT_W'(1);
        end else begin
            out_next_s = out_cnt_r;
        end
        if (hs_s) begin
            remaining_next_s = remaining_r - burst_bytes_s;
        end else begin
            remaining_next_s = remaining_r;
        end
`ifdef AXI_DMA_WR_BURST_ABORT_EN
        stop_s = err_r || bad_resp_s || aborted_r || abort;
`else
        stop_s = err_r || bad_resp_s;
`endif
    end

    // Command FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            remaining_r <= '0;
            fixed_r     <= 1'b0;
            lock_r      <= 1'b0;
            out_cnt_r   <= '0;
            valid_r     <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
`ifdef AXI_DMA_WR_BURST_ABORT_EN
            aborted_r   <= 1'b0;
`endif
        end else begin
            out_cnt_r <= out_next_s;
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (cmd_valid && cmd_ready_r) begin
                        addr_r      <= cmd_addr;
                        remaining_r <= cmd_byte_cnt;
                        fixed_r     <= cmd_fixed;
                        lock_r      <= cmd_lock;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        err_r       <= cmd_bad_s;
`ifdef AXI_DMA_WR_BURST_ABORT_EN
                        aborted_r   <= 1'b0;
`endif
                        state_r     <= cmd_bad_s ? ST_DONE : ST_ISSUE;
                        valid_r     <= !cmd_bad_s;
                    end
                end
                ST_ISSUE: begin
                    err_r <= err_r | bad_resp_s;
`ifdef AXI_DMA_WR_BURST_ABORT_EN
                    if (abort) begin
                        aborted_r <= 1'b1;
                    end
`endif
                    if (hs_s) begin
                        remaining_r <= remaining_next_s;
                        if (!fixed_r) begin
                            addr_r <= addr_r + AW'(burst_bytes_s);
                        end
                    end
                    // A presented burst must complete before issue can stop.
                    if (valid_r && !req_if.ready) begin
                        valid_r <= 1'b1;
                    end else if ((remaining_next_s == '0) || stop_s) begin
                        valid_r <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        valid_r <= (out_next_s < OUT_W'(MAX_OUTSTANDING));
                    end
                end
                ST_DRAIN: begin
                    err_r <= err_r | bad_resp_s;
                    if (out_next_s == '0) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    valid_r     <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_if.valid    = valid_r;
    assign req_if.addr     = addr_r;
    assign req_if.byte_len = burst_len_s;
    assign req_if.fixed    = fixed_r;
    assign req_if.lock     = lock_r;
    assign cmd_ready       = cmd_ready_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err             = err_r;
`ifdef AXI_DMA_WR_BURST_ABORT_EN
    assign aborted         = aborted_r;
`endif

endmodule

// File: tb/tb_axi_dma_wr_burst_gen.sv
// Directed bench for axi_dma_wr_burst_gen (DW=32, MAX_OUTSTANDING=2).
module tb_axi_dma_wr_burst_gen;
    localparam int AW = 32, DW = 32, LEN_W = 32, MO = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_addr = '0;
    logic [LEN_W-1:0] cmd_byte_cnt = '0;
    logic             cmd_fixed = 1'b0;
    logic             cmd_lock = 1'b0;
    logic             busy, done, err;
`ifdef AXI_DMA_WR_BURST_ABORT_EN
    logic             abort = 1'b0;
    logic             aborted;
`endif

    int checks = 0, errors = 0, hs_count = 0, resp_sent = 0, valid_cycles = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_len[$];
    logic        q_fixed[$];
    logic        q_lock[$];

    always #5 clk = ~clk;

    axi_dma_req_if #(.AW(AW), .LEN_W(LEN_W)) req_bus ();

    axi_dma_wr_burst_gen #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .MAX_OUTSTANDING(MO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_byte_cnt (cmd_byte_cnt),
        .cmd_fixed    (cmd_fixed),
        .cmd_lock     (cmd_lock),
        .req_if       (req_bus),
`ifdef AXI_DMA_WR_BURST_ABORT_EN
        .abort        (abort),
        .aborted      (aborted),
`endif
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Record every accepted burst and every cycle valid is presented.
    always @(posedge clk) begin
        if (rst_n && req_bus.valid) begin
            valid_cycles++;
            if (req_bus.ready) begin
                q_addr.push_back(req_bus.addr);
                q_len.push_back(req_bus.byte_len);
                q_fixed.push_back(req_bus.fixed);
                q_lock.push_back(req_bus.lock);
                hs_count++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] c, input logic f, input logic l);
        @(negedge clk);
        check("cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_addr = a; cmd_byte_cnt = c; cmd_fixed = f; cmd_lock = l; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_resp(input logic [1:0] r);
        req_bus.resp = r;
        req_bus.resp_valid = 1'b1;
        resp_sent++;
        @(negedge clk);
        req_bus.resp_valid = 1'b0;
        req_bus.resp = 2'b00;
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_count < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_hs", 64'(hs_count), 64'(target));
    endtask

    task automatic respond_until(input int target);
        int n = 0;
        while (resp_sent < target && n < 400) begin
            if (hs_count > resp_sent) send_resp(2'b00);
            else @(negedge clk);
            n++;
        end
        check("resp_all", 64'(resp_sent), 64'(target));
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        int base, qb, vc;
        req_bus.ready = 1'b1;
        req_bus.resp = 2'b00;
        req_bus.resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_valid", 64'(req_bus.valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;

        // INCR 0x1000 / 0x800: two 1KB bursts.
        base = hs_count; qb = q_addr.size();
        send_cmd(32'h1000, 32'h800, 1'b0, 1'b0);
        wait_hs(base + 2);
        check("t1_valid_low", 64'(req_bus.valid), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_addr0", 64'(q_addr[qb]), 64'h1000);
        check("t1_len0", 64'(q_len[qb]), 64'h3FC);
        check("t1_addr1", 64'(q_addr[qb+1]), 64'h1400);
        check("t1_len1", 64'(q_len[qb+1]), 64'h3FC);
        respond_until(base + 2);
        wait_done();
        check("t1_err", 64'(err), 64'd0);
        check("t1_ready_at_done", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        check("t1_done_pulse", 64'(done), 64'd0);

        // INCR across the 4KB page: 0x0FF0 / 0x20.
        base = hs_count; qb = q_addr.size();
        send_cmd(32'h0FF0, 32'h20, 1'b0, 1'b0);
        respond_until(base + 2);
        wait_done();
        check("t2_bursts", 64'(hs_count), 64'(base + 2));
        check("t2_addr0", 64'(q_addr[qb]), 64'h0FF0);
        check("t2_len0", 64'(q_len[qb]), 64'h0C);
        check("t2_addr1", 64'(q_addr[qb+1]), 64'h1000);
        check("t2_len1", 64'(q_len[qb+1]), 64'h0C);
        check("t2_err", 64'(err), 64'd0);

        // FIXED 0x2000 / 0x100 with lock: four 16-beat bursts at the same address.
        base = hs_count; qb = q_addr.size();
        send_cmd(32'h2000, 32'h100, 1'b1, 1'b1);
        respond_until(base + 4);
        wait_done();
        check("t3_bursts", 64'(hs_count), 64'(base + 4));
        for (int i = 0; i < 4; i++) begin
            check("t3_addr", 64'(q_addr[qb+i]), 64'h2000);
            check("t3_len", 64'(q_len[qb+i]), 64'h3C);
            check("t3_fixed", 64'(q_fixed[qb+i]), 64'd1);
            check("t3_lock", 64'(q_lock[qb+i]), 64'd1);
        end
        check("t3_err", 64'(err), 64'd0);

        // Outstanding limit: responses withheld after two bursts.
        base = hs_count;
        send_cmd(32'h0, 32'h1000, 1'b0, 1'b0);
        wait_hs(base + 2);
        repeat (3) @(negedge clk);
        check("t4_valid_held_low", 64'(req_bus.valid), 64'd0);
        check("t4_no_more_hs", 64'(hs_count), 64'(base + 2));
        send_resp(2'b00);
        check("t4_valid_rise", 64'(req_bus.valid), 64'd1);
        respond_until(base + 4);
        wait_done();
        check("t4_bursts", 64'(hs_count), 64'(base + 4));
        check("t4_err", 64'(err), 64'd0);

        // SLVERR while a burst is held by ready=0.
        base = hs_count;
        send_cmd(32'h0, 32'h1000, 1'b0, 1'b0);
        wait_hs(base + 1);
        req_bus.ready = 1'b0;
        send_resp(2'b10);
        check("t5_valid_kept", 64'(req_bus.valid), 64'd1);
        check("t5_addr_stable", 64'(req_bus.addr), 64'h400);
        @(negedge clk);
        check("t5_addr_stable2", 64'(req_bus.addr), 64'h400);
        req_bus.ready = 1'b1;
        @(negedge clk);
        check("t5_inflight_hs", 64'(hs_count), 64'(base + 2));
        check("t5_valid_low", 64'(req_bus.valid), 64'd0);
        repeat (3) @(negedge clk);
        check("t5_no_more_hs", 64'(hs_count), 64'(base + 2));
        check("t5_no_early_done", 64'(done), 64'd0);
        check("t5_busy", 64'(busy), 64'd1);
        send_resp(2'b00);
        wait_done();
        check("t5_err", 64'(err), 64'd1);

        // Misaligned address: no request, done two cycles after accept.
        vc = valid_cycles;
        send_cmd(32'h1002, 32'h10, 1'b0, 1'b0);
        check("t6_done_c1", 64'(done), 64'd0);
        @(negedge clk);
        check("t6_done_c2", 64'(done), 64'd1);
        check("t6_err", 64'(err), 64'd1);
        @(negedge clk);
        check("t6_done_pulse", 64'(done), 64'd0);
        send_cmd(32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_zero_done", 64'(done), 64'd1);
        check("t6_zero_err", 64'(err), 64'd1);
        check("t6_no_valid", 64'(valid_cycles), 64'(vc));

        // Next legal command clears err.
        base = hs_count; qb = q_addr.size();
        send_cmd(32'h3000, 32'h10, 1'b0, 1'b0);
        check("t6_err_cleared", 64'(err), 64'd0);
        respond_until(base + 1);
        wait_done();
        check("t6_len", 64'(q_len[qb]), 64'h0C);
        check("t6_err_final", 64'(err), 64'd0);

        // Reset in the middle of a command.
        base = hs_count;
        send_cmd(32'h0, 32'h1000, 1'b0, 1'b0);
        wait_hs(base + 1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t7_rst_valid", 64'(req_bus.valid), 64'd0);
        check("t7_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t7_idle_valid", 64'(req_bus.valid), 64'd0);
        check("t7_idle_ready", 64'(cmd_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
